// File: rtl/ct_f_spsram_pclr_if.sv
// Access bus of the single-port clearable SRAM model: request/data from the
// cache controller (master) and read data plus clear-busy from the array (slave).
interface ct_f_spsram_pclr_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int WEN_GRAN   = 1
);
  logic                           CEN;
  logic                           GWEN;
  logic [ADDR_WIDTH-1:0]          A;
  logic [DATA_WIDTH-1:0]          D;
  logic [DATA_WIDTH/WEN_GRAN-1:0] WEN;
  logic                           INIT_REQ;
  logic [DATA_WIDTH-1:0]          Q;
  logic                           INIT_BUSY;

  modport master (
    output CEN, GWEN, A, D, WEN, INIT_REQ,
    input  Q, INIT_BUSY
  );

  modport slave (
    input  CEN, GWEN, A, D, WEN, INIT_REQ,
    output Q, INIT_BUSY
  );
endinterface

// File: rtl/ct_f_spsram_pclr.sv
// Single-port SRAM model with grouped write mask, optional extra read register and
// a clear sequencer that zeroes the array, built only when CT_F_SPSRAM_PCLR_INIT_EN is defined.
module ct_f_spsram_pclr #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int WEN_GRAN   = 1,
  parameter int RD_PIPE    = 0
) (
  input logic               CLK,
  input logic               RST_B,
  ct_f_spsram_pclr_if.slave bus
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int GROUPS = DATA_WIDTH / WEN_GRAN;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  acc_p0;
  logic                  rd_p0;
  logic                  wr_p0;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] rd_data_p1;

`ifdef CT_F_SPSRAM_PCLR_INIT_EN
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_nxt;

  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter wraps to zero on the last address, so re-entry needs no extra load.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.INIT_REQ) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == {ADDR_WIDTH{1'b1}}) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;
`else
  logic unused_init_req;

  assign busy            = 1'b0;
  assign clr_we          = 1'b0;
  assign clr_addr        = '0;
  assign unused_init_req = bus.INIT_REQ;
`endif

  assign bus.INIT_BUSY = busy;

  // stage 0: access decode, array write port
  assign acc_p0 = RST_B && !bus.CEN && !busy;
  assign rd_p0  = acc_p0 && bus.GWEN;
  assign wr_p0  = acc_p0 && !bus.GWEN;

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_p0) begin
      for (int g = 0; g < GROUPS; g++) begin
        if (!bus.WEN[g]) mem[bus.A][g*WEN_GRAN +: WEN_GRAN] <= bus.D[g*WEN_GRAN +: WEN_GRAN];
      end
    end
  end

  // stage 1: read register
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1 <= rd_p0;
      if (rd_p0) rd_data_p1 <= mem[bus.A];
    end
  end

  // stage 2: optional output register, loads only behind a fresh stage-1 read
  generate
    if (RD_PIPE != 0) begin : g_pipe
      logic [DATA_WIDTH-1:0] rd_data_p2;

      always_ff @(posedge CLK) begin
        if (!RST_B) rd_data_p2 <= '0;
        else if (vld_p1) rd_data_p2 <= rd_data_p1;
      end

      assign bus.Q = rd_data_p2;
    end else begin : g_nopipe
      logic unused_vld_p1;

      assign unused_vld_p1 = vld_p1;
      assign bus.Q         = rd_data_p1;
    end
  endgenerate
endmodule

// File: doc/ct_f_spsram_pclr.md
# ct_f_spsram_pclr

Parametrised FPGA single-port SRAM model for the C910 FPGA build, the successor of the fixed 1024x64 bit-mask wrapper. Adds configurable write-mask granularity, an optional extra output pipeline stage and a hardware clear sequencer that zeroes the whole array after reset or on request. It is a drop-in for cache data, tag and BHT arrays whose control logic tolerates a busy window after reset.

## Interface
Parameters:
- ADDR_WIDTH, 10, address bits; depth = 2^ADDR_WIDTH
- DATA_WIDTH, 64, data bits
- WEN_GRAN, 1, data bits per write-enable bit; DATA_WIDTH must be a multiple of WEN_GRAN
- RD_PIPE, 0, 0 = 1-cycle read; 1 = extra output register, 2-cycle read

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST_B  in  1  reset, synchronous, active-low
- CEN  in  1  chip enable, active-low
- GWEN  in  1  global write enable, active-low; 1 = read
- A  in  ADDR_WIDTH  address
- D  in  DATA_WIDTH  write data
- WEN  in  DATA_WIDTH/WEN_GRAN  per-group write enable, active-low
- INIT_REQ  in  1  single-cycle request to re-clear the array
- Q  out  DATA_WIDTH  read data
- INIT_BUSY  out  1  clear in progress; accesses ignored

## Operation
- Read: CEN=0, GWEN=1 -> data at A captured into read register; Q holds it until the next completed read.
- Write: CEN=0, GWEN=0 -> group g (bits g*WEN_GRAN+WEN_GRAN-1 : g*WEN_GRAN) written from D when WEN[g]=0; other groups unchanged. Writes do not change Q.
- CEN=1: no array access; Q holds.
- RD_PIPE=1: stage-2 register loads from stage-1 only in the cycle after stage-1 loaded (valid bit); Q = stage-2.
- Clear sequencer states: IDLE, CLEAR.
  - RST_B=0 -> CLEAR, counter=0.
  - CLEAR: write all-zero to array[counter], counter+1 each cycle; at counter = 2^ADDR_WIDTH-1 write it and go IDLE.
  - IDLE + INIT_REQ=1 -> CLEAR, counter=0.
  - INIT_REQ during CLEAR ignored (no restart).
- During CLEAR external CEN/GWEN/WEN/D ignored: writes dropped, reads do not update Q.
- INIT_REQ and a valid access in the same IDLE cycle: access completes, CLEAR starts next cycle.
- Reset mid-CLEAR: counter restarts at 0.

## Timing
- Reset values: Q = 0, stage-1/stage-2 registers and valid bits = 0, INIT_BUSY = 1 (with clear enabled), counter = 0.
- Read latency: RD_PIPE=0 -> access sampled at edge N, Q valid after edge N; RD_PIPE=1 -> Q valid after edge N+1.
- Write at edge N visible to a read sampled at edge N+1 (no same-cycle bypass needed; single port).
- Clear length: exactly 2^ADDR_WIDTH cycles of INIT_BUSY=1 after reset deassert or after the INIT_REQ cycle; first accepted access is at the edge where INIT_BUSY is sampled 0.
- INIT_BUSY is a register output; deasserts after the edge that writes the last address.

## Configuration
- CT_F_SPSRAM_PCLR_INIT_EN defined: clear sequencer built as above.
- Not defined: no sequencer, no counter; INIT_BUSY tied 0; INIT_REQ ignored; array contents uninitialised (X in simulation) after reset; accesses accepted from the first cycle after reset. Q and pipe registers still reset to 0.

## Test plan
- Macro on, ADDR_WIDTH=4: deassert RST_B, count INIT_BUSY high -> exactly 16 cycles; then read all 16 addresses -> Q=0 each.
- WEN_GRAN=8: write 0xFFFF_FFFF_FFFF_FFFF to addr 3, then write 0x1122_3344_5566_7788 with WEN=0xF0 -> read addr 3 returns 0xFFFF_FFFF_5566_7788.
- RD_PIPE=1: read addr 5 (holding 0xA5) at edge N -> Q=0xA5 after edge N+1, unchanged after edge N; idle 3 cycles -> Q stays 0xA5.
- Write addr 7 = 0x55 while INIT_BUSY=1 -> dropped; after clear, read addr 7 -> 0.
- Write addr 2 = 0x99, pulse INIT_REQ with a read of addr 2 in the same cycle -> Q=0x99, then INIT_BUSY for 2^ADDR_WIDTH cycles, subsequent read of addr 2 -> 0; RST_B low for one cycle mid-clear -> busy count restarts at full length.
